// File: rtl/sm_debug_ctrl_pkg.sv
// Shared state and halt-cause codes for the sm_cpu run/halt/step sequencer.
package sm_debug_ctrl_pkg;

    typedef enum logic [1:0] {
        SDC_HALT = 2'd0,
        SDC_RUN  = 2'd1,
        SDC_STEP = 2'd2
    } sdcState_t;

    localparam logic [1:0] SDC_CAUSE_HOST      = 2'd0;
    localparam logic [1:0] SDC_CAUSE_STEP_DONE = 2'd1;
    localparam logic [1:0] SDC_CAUSE_BREAK     = 2'd2;
    localparam logic [1:0] SDC_CAUSE_TIMEOUT   = 2'd3;

endpackage

// File: rtl/sm_debug_ctrl.sv
// Run/halt/single-step sequencer: gates sm_cpu with cpu_en and reports why it stopped.
import sm_debug_ctrl_pkg::*;

module sm_debug_ctrl #(
    parameter bit RESET_RUN = 1'b0,
    parameter int STEP_W    = 8,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_run,
    input  logic              cmd_halt,
    input  logic              cmd_step,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bp_en,
    input  logic [31:0]       bp_addr,
    input  logic [CNT_W-1:0]  cycle_limit,
    input  logic [31:0]       pc,
    output logic              cpu_en,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic [CNT_W-1:0]  cycle_cnt
);

    sdcState_t         state, stateNext;
    logic [1:0]        haltCause, causeNext;
    logic [STEP_W-1:0] stepLeft, stepLeftNext;
    logic [CNT_W-1:0]  cycleCnt;
    logic              bpSkip, bpSkipNext;
    logic              cntClear, bpHit, timeout, cpuEn;

    // A step command of zero still executes one instruction.
    function automatic logic [STEP_W-1:0] stepLoad(input logic [STEP_W-1:0] n);
        return (n == '0) ? STEP_W'(1) : n;
    endfunction

    always_comb begin
        bpHit        = bp_en && (pc == bp_addr) && !bpSkip;
        timeout      = (cycle_limit != '0) && (cycleCnt >= cycle_limit);
        cpuEn        = 1'b0;
        stateNext    = state;
        causeNext    = haltCause;
        stepLeftNext = stepLeft;
        cntClear     = 1'b0;

        case (state)
            SDC_RUN:  cpuEn = !bpHit && !timeout;
            SDC_STEP: cpuEn = !bpHit;
            default:  cpuEn = 1'b0;
        endcase

        // The breakpoint mask lasts only for the first executed instruction after resuming.
        bpSkipNext = bpSkip && !cpuEn;

        case (state)
            SDC_HALT: begin
                if (!cmd_halt && cmd_step) begin
                    stateNext    = SDC_STEP;
                    stepLeftNext = stepLoad(step_count);
                    bpSkipNext   = 1'b1;
                    cntClear     = 1'b1;
                end else if (!cmd_halt && cmd_run) begin
                    stateNext  = SDC_RUN;
                    bpSkipNext = 1'b1;
                    cntClear   = 1'b1;
                end
            end
            SDC_RUN: begin
                if (cmd_halt) begin
                    stateNext = SDC_HALT;
                    causeNext = SDC_CAUSE_HOST;
                end else if (bpHit) begin
                    stateNext = SDC_HALT;
                    causeNext = SDC_CAUSE_BREAK;
                end else if (timeout) begin
                    stateNext = SDC_HALT;
                    causeNext = SDC_CAUSE_TIMEOUT;
                end else if (cmd_step) begin
                    stateNext    = SDC_STEP;
                    stepLeftNext = stepLoad(step_count);
                    bpSkipNext   = 1'b1;
                    cntClear     = 1'b1;
                end
            end
            SDC_STEP: begin
                if (cpuEn) stepLeftNext = stepLeft - 1'b1;
                if (cmd_halt) begin
                    stateNext = SDC_HALT;
                    causeNext = SDC_CAUSE_HOST;
                end else if (bpHit) begin
                    stateNext = SDC_HALT;
                    causeNext = SDC_CAUSE_BREAK;
                end else if (stepLeft == STEP_W'(1)) begin
                    stateNext = SDC_HALT;
                    causeNext = SDC_CAUSE_STEP_DONE;
                end else if (cmd_run && !cmd_step) begin
                    stateNext  = SDC_RUN;
                    bpSkipNext = 1'b1;
                    cntClear   = 1'b1;
                end
            end
            default: stateNext = SDC_HALT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RESET_RUN ? SDC_RUN : SDC_HALT;
            halted    <= !RESET_RUN;
            haltCause <= SDC_CAUSE_HOST;
            stepLeft  <= '0;
            bpSkip    <= 1'b0;
            cycleCnt  <= '0;
        end else begin
            state     <= stateNext;
            halted    <= (stateNext == SDC_HALT);
            haltCause <= causeNext;
            stepLeft  <= stepLeftNext;
            bpSkip    <= bpSkipNext;
            // Saturate rather than wrap so a long run never looks freshly started.
            if (cntClear)
                cycleCnt <= '0;
            else if (cpuEn && (cycleCnt != '1))
                cycleCnt <= cycleCnt + 1'b1;
        end
    end

    assign cpu_en     = cpuEn;
    assign halt_cause = haltCause;
    assign cycle_cnt  = cycleCnt;

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Bench for sm_debug_ctrl: directed scenarios followed by random commands against a reference model.
module tb_sm_debug_ctrl;

    localparam int STEP_W = 8;
    localparam int CNT_W  = 8;
    localparam int MAXCNT = (1 << CNT_W) - 1;
    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_run, cmd_halt, cmd_step;
    logic [STEP_W-1:0] step_count;
    logic              bp_en;
    logic [31:0]       bp_addr;
    logic [CNT_W-1:0]  cycle_limit;
    logic [31:0]       pc;
    logic [31:0]       v0;
    logic              cpu_en, halted;
    logic [1:0]        halt_cause;
    logic [CNT_W-1:0]  cycle_cnt;

    int errors = 0;
    int checks = 0;
    int enCount;
    int mMode, mCause, mCnt, mLeft;
    bit mSkip;
    logic [31:0] pcSave;

    sm_debug_ctrl #(.RESET_RUN(1'b0), .STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
        .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr),
        .cycle_limit(cycle_limit), .pc(pc),
        .cpu_en(cpu_en), .halted(halted), .halt_cause(halt_cause), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in CPU: sequential fetch, v0 accumulates the address of every executed instruction.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= 32'd0;
            v0 <= 32'd0;
        end else if (cpu_en) begin
            pc <= pc + 32'd1;
            v0 <= v0 + pc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mMode  = M_HALT;
        mCause = 0;
        mCnt   = 0;
        mLeft  = 0;
        mSkip  = 1'b0;
    endtask

    task automatic startStep();
        mMode = M_STEP;
        mLeft = (step_count == 0) ? 1 : int'(step_count);
        mSkip = 1'b1;
        mCnt  = 0;
    endtask

    task automatic startRun();
        mMode = M_RUN;
        mSkip = 1'b1;
        mCnt  = 0;
    endtask

    task automatic stop(input int cause);
        mMode  = M_HALT;
        mCause = cause;
    endtask

    // One clock: inputs are set by the caller after the previous edge; pulses drop after this edge.
    task automatic cycle();
        bit hit, tmo, expEn;
        #1;
        hit   = bp_en && (pc == bp_addr) && !mSkip;
        tmo   = (mMode == M_RUN) && (cycle_limit != 0) && (mCnt >= int'(cycle_limit));
        expEn = ((mMode == M_RUN) && !hit && !tmo) || ((mMode == M_STEP) && !hit);
        check("cpu_en", {31'd0, cpu_en}, {31'd0, expEn});
        if (cpu_en) enCount++;
        if (expEn) begin
            if (mCnt < MAXCNT) mCnt++;
            mSkip = 1'b0;
            if (mMode == M_STEP) mLeft--;
        end
        case (mMode)
            M_HALT: begin
                if (!cmd_halt && cmd_step) startStep();
                else if (!cmd_halt && cmd_run) startRun();
            end
            M_RUN: begin
                if (cmd_halt) stop(0);
                else if (hit) stop(2);
                else if (tmo) stop(3);
                else if (cmd_step) startStep();
            end
            default: begin
                if (cmd_halt) stop(0);
                else if (hit) stop(2);
                else if (mLeft == 0) stop(1);
                else if (cmd_run && !cmd_step) startRun();
            end
        endcase
        @(posedge clk);
        #1;
        check("halted", {31'd0, halted}, {31'd0, mMode == M_HALT});
        check("halt_cause", {30'd0, halt_cause}, mCause);
        check("cycle_cnt", {24'd0, cycle_cnt}, mCnt);
        cmd_run  = 1'b0;
        cmd_halt = 1'b0;
        cmd_step = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        modelReset();
        check("rst_cpu_en", {31'd0, cpu_en}, 0);
        check("rst_halted", {31'd0, halted}, 1);
        check("rst_cycle_cnt", {24'd0, cycle_cnt}, 0);
        check("rst_cause", {30'd0, halt_cause}, 0);
        check("rst_pc", pc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitHalt(input int budget);
        for (int i = 0; i < budget && !halted; i++) cycle();
        check("halt_within_budget", {31'd0, halted}, 1);
    endtask

    initial begin
        rst = 1'b1;
        cmd_run = 1'b0; cmd_halt = 1'b0; cmd_step = 1'b0;
        step_count = '0; bp_en = 1'b0; bp_addr = 32'd0; cycle_limit = '0;
        enCount = 0;
        #12;
        doReset();

        // Held in HALT after reset
        repeat (20) cycle();
        check("hold_pc", pc, 0);
        check("hold_halted", {31'd0, halted}, 1);

        // Step three instructions, then a zero-count step
        enCount = 0;
        step_count = 8'd3; cmd_step = 1'b1;
        cycle();
        waitHalt(10);
        check("step3_enables", enCount, 3);
        check("step3_pc", pc, 3);
        check("step3_cause", {30'd0, halt_cause}, 1);
        check("step3_v0", v0, 3);
        enCount = 0;
        step_count = 8'd0; cmd_step = 1'b1;
        cycle();
        waitHalt(10);
        check("step0_enables", enCount, 1);
        check("step0_pc", pc, 4);

        // Breakpoint stop and resume past it
        doReset();
        bp_en = 1'b1; bp_addr = 32'd5; cmd_run = 1'b1;
        cycle();
        waitHalt(20);
        check("bp_pc", pc, 5);
        check("bp_cause", {30'd0, halt_cause}, 2);
        check("bp_cycle_cnt", {24'd0, cycle_cnt}, 5);
        cmd_run = 1'b1;
        cycle();
        cycle();
        check("bp_resume_pc", pc, 6);
        repeat (3) cycle();
        cmd_halt = 1'b1;
        cycle();
        cycle();
        check("host_halt_cause", {30'd0, halt_cause}, 0);
        bp_en = 1'b0;

        // Timeout
        cycle_limit = 8'd10; cmd_run = 1'b1;
        cycle();
        waitHalt(30);
        check("tmo_cycle_cnt", {24'd0, cycle_cnt}, 10);
        check("tmo_cause", {30'd0, halt_cause}, 3);
        cycle_limit = '0;

        // Halt and step together while running: halt wins
        cmd_run = 1'b1;
        cycle();
        repeat (3) cycle();
        cmd_halt = 1'b1; cmd_step = 1'b1; step_count = 8'd5;
        cycle();
        check("halt_step_halted", {31'd0, halted}, 1);
        check("halt_step_cause", {30'd0, halt_cause}, 0);
        pcSave = pc;
        repeat (5) cycle();
        check("halt_step_pc_frozen", pc, pcSave);

        // Counter saturation
        cmd_run = 1'b1;
        cycle();
        repeat (300) cycle();
        check("cnt_saturated", {24'd0, cycle_cnt}, MAXCNT);
        cmd_halt = 1'b1;
        cycle();

        // Reset in the middle of a step sequence
        step_count = 8'd8; cmd_step = 1'b1;
        cycle();
        repeat (4) cycle();
        doReset();
        enCount = 0;
        step_count = 8'd2; cmd_step = 1'b1;
        cycle();
        waitHalt(10);
        check("post_rst_step_enables", enCount, 2);

        // Stepped execution must leave v0 as a free run to the same pc would
        foreach (pcSave[i]) if (i < 4) begin
            step_count = STEP_W'(i * 3); cmd_step = 1'b1;
            cycle();
            waitHalt(20);
        end
        cmd_run = 1'b1;
        cycle();
        repeat (9) cycle();
        cmd_halt = 1'b1;
        cycle();
        check("v0_trace", v0, (pc * (pc - 32'd1)) / 32'd2);

        // Random commands against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) cmd_halt = 1'b1;
            else if (r < 7) begin
                cmd_step = 1'b1;
                step_count = STEP_W'($urandom_range(0, 6));
            end else if (r < 11) cmd_run = 1'b1;
            else if (r == 11) begin
                bp_en = ~bp_en;
                bp_addr = pc + 32'($urandom_range(0, 15));
            end else if (r == 12) cycle_limit = ($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(3, 40));
            if (r < 7 && $urandom_range(0, 3) == 0) cmd_run = 1'b1;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
